// File: rtl/adc_window_stats_if.sv
// ---------------------------------------------------------------------------
// adc_window_stats_if
//  Bundles the ADC sample stream, the window restart strobe and the published
//  per-channel window statistics of adc_window_stats.
//  master : sample producer / result consumer (capture stage, bus, testbench)
//  slave  : the statistics block
//  Signals
//   smp_vld  1   sample strobe, one cycle per sample
//   smp_ch   1   channel tag (0 = ch0, 1 = ch1)
//   smp_dat  DW  sample value, unsigned offset-binary
//   clr      1   synchronous restart of both running windows
//   max0/1   DW  published window maximum
//   pp0/1    DW  published peak-to-peak
//   avg0/1   DW  published truncated window mean
//   clip     2   published clip flag per channel ([0] = ch0)
//   upd      2   one-cycle refresh pulse per channel
// ---------------------------------------------------------------------------
interface adc_window_stats_if #(
    parameter int DW = 14
);
    logic          smp_vld;
    logic          smp_ch;
    logic [DW-1:0] smp_dat;
    logic          clr;
    logic [DW-1:0] max0;
    logic [DW-1:0] max1;
    logic [DW-1:0] pp0;
    logic [DW-1:0] pp1;
    logic [DW-1:0] avg0;
    logic [DW-1:0] avg1;
    logic [1:0]    clip;
    logic [1:0]    upd;

    modport master (
        output smp_vld, smp_ch, smp_dat, clr,
        input  max0, max1, pp0, pp1, avg0, avg1, clip, upd
    );

    modport slave (
        input  smp_vld, smp_ch, smp_dat, clr,
        output max0, max1, pp0, pp1, avg0, avg1, clip, upd
    );
endinterface

// File: rtl/adc_window_stats.sv
// ---------------------------------------------------------------------------
// adc_window_stats
//  Per-channel statistics over fixed windows of 2**WIN_LOG2 samples for a
//  two-channel ADC stream: maximum, peak-to-peak, truncated mean and a clip
//  flag. Results are published once per window and held stable in between.
//  Ports
//   clk_i-style scalars : clk (system clock), rst (async reset, active-high)
//   bus                 : adc_window_stats_if.slave (samples in, results out)
//  Parameters
//   DW        sample width (unsigned offset-binary)
//   WIN_LOG2  log2 of the window length per channel (1..16)
// ---------------------------------------------------------------------------
module adc_window_stats #(
    parameter int DW       = 14,
    parameter int WIN_LOG2 = 10
) (
    input logic                clk,
    input logic                rst,
    adc_window_stats_if.slave  bus
);

    localparam int AW = DW + WIN_LOG2;

    // Helpers kept as functions so the comparison/flag logic reads the same
    // for both channels.
    function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] umin(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic is_clip(input logic [DW-1:0] d);
        return (d == {DW{1'b0}}) || (d == {DW{1'b1}});
    endfunction

    // Running window state, one entry per channel
    logic [DW-1:0]       run_max_q [2];
    logic [DW-1:0]       run_max_d [2];
    logic [DW-1:0]       run_min_q [2];
    logic [DW-1:0]       run_min_d [2];
    logic [AW-1:0]       acc_q     [2];
    logic [AW-1:0]       acc_d     [2];
    logic [WIN_LOG2-1:0] cnt_q     [2];
    logic [WIN_LOG2-1:0] cnt_d     [2];
    logic [1:0]          run_clip_q;
    logic [1:0]          run_clip_d;

    // Published results
    logic [DW-1:0]       pub_max_q [2];
    logic [DW-1:0]       pub_max_d [2];
    logic [DW-1:0]       pub_pp_q  [2];
    logic [DW-1:0]       pub_pp_d  [2];
    logic [DW-1:0]       pub_avg_q [2];
    logic [DW-1:0]       pub_avg_d [2];
    logic [1:0]          pub_clip_q;
    logic [1:0]          pub_clip_d;
    logic [1:0]          upd_q;
    logic [1:0]          upd_d;

    // Candidate running values if the current sample is accepted
    logic [DW-1:0]       new_max_s [2];
    logic [DW-1:0]       new_min_s [2];
    logic [AW-1:0]       new_acc_s [2];
    logic [1:0]          new_clip_s;
    logic [1:0]          hit_s;
    logic [1:0]          win_end_s;

    // Candidate running values and accept / window-end decode per channel
    always_comb begin
        new_clip_s = 2'b00;
        hit_s      = 2'b00;
        win_end_s  = 2'b00;
        for (int c = 0; c < 2; c++) begin
            new_max_s[c]  = umax(run_max_q[c], bus.smp_dat);
            new_min_s[c]  = umin(run_min_q[c], bus.smp_dat);
            new_acc_s[c]  = acc_q[c] + {{WIN_LOG2{1'b0}}, bus.smp_dat};
            new_clip_s[c] = run_clip_q[c] | is_clip(bus.smp_dat);
            // clr wins over a simultaneous strobe, so it masks acceptance
            hit_s[c]      = bus.smp_vld & ~bus.clr & (bus.smp_ch == 1'(c));
            win_end_s[c]  = hit_s[c] & (cnt_q[c] == {WIN_LOG2{1'b1}});
        end
    end

    // Next-state for running and published state of both channels
    always_comb begin
        run_max_d  = run_max_q;
        run_min_d  = run_min_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        run_clip_d = run_clip_q;
        pub_max_d  = pub_max_q;
        pub_pp_d   = pub_pp_q;
        pub_avg_d  = pub_avg_q;
        pub_clip_d = pub_clip_q;
        upd_d      = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (bus.clr || win_end_s[c]) begin
                // Window restart: running state back to its empty-window values
                run_max_d[c]  = {DW{1'b0}};
                run_min_d[c]  = {DW{1'b1}};
                acc_d[c]      = {AW{1'b0}};
                cnt_d[c]      = {WIN_LOG2{1'b0}};
                run_clip_d[c] = 1'b0;
            end else if (hit_s[c]) begin
                run_max_d[c]  = new_max_s[c];
                run_min_d[c]  = new_min_s[c];
                acc_d[c]      = new_acc_s[c];
                cnt_d[c]      = cnt_q[c] + WIN_LOG2'(1);
                run_clip_d[c] = new_clip_s[c];
            end else begin
                run_max_d[c]  = run_max_q[c];
            end

            if (win_end_s[c]) begin
                // Published values include the window's final sample
                pub_max_d[c]  = new_max_s[c];
                pub_pp_d[c]   = new_max_s[c] - new_min_s[c];
                pub_avg_d[c]  = new_acc_s[c][AW-1:WIN_LOG2];
                pub_clip_d[c] = new_clip_s[c];
                upd_d[c]      = 1'b1;
            end else begin
                upd_d[c]      = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                run_max_q[c] <= {DW{1'b0}};
                run_min_q[c] <= {DW{1'b1}};
                acc_q[c]     <= {AW{1'b0}};
                cnt_q[c]     <= {WIN_LOG2{1'b0}};
                pub_max_q[c] <= {DW{1'b0}};
                pub_pp_q[c]  <= {DW{1'b0}};
                pub_avg_q[c] <= {DW{1'b0}};
            end
            run_clip_q <= 2'b00;
            pub_clip_q <= 2'b00;
            upd_q      <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                run_max_q[c] <= run_max_d[c];
                run_min_q[c] <= run_min_d[c];
                acc_q[c]     <= acc_d[c];
                cnt_q[c]     <= cnt_d[c];
                pub_max_q[c] <= pub_max_d[c];
                pub_pp_q[c]  <= pub_pp_d[c];
                pub_avg_q[c] <= pub_avg_d[c];
            end
            run_clip_q <= run_clip_d;
            pub_clip_q <= pub_clip_d;
            upd_q      <= upd_d;
        end
    end

    assign bus.max0 = pub_max_q[0];
    assign bus.max1 = pub_max_q[1];
    assign bus.pp0  = pub_pp_q[0];
    assign bus.pp1  = pub_pp_q[1];
    assign bus.avg0 = pub_avg_q[0];
    assign bus.avg1 = pub_avg_q[1];
    assign bus.clip = pub_clip_q;
    assign bus.upd  = upd_q;

endmodule
